// File: rtl/spi_shifter.sv
// SPI host data shift stage: drives MOSI and samples MISO on edge pulses
// from the SPI clock generator, using one shared TX/RX character register.
//
// Ports:
//   clk_i, rst_ni          system clock, async active-low reset
//   len, lsb               character length (0 = DATA_W bits), bit order
//   tx_negedge, rx_negedge edge select for driving MOSI / sampling MISO
//   go                     start-transfer pulse (ignored while tip)
//   pos_edge, neg_edge     serial clock edge pulses from the clock generator
//   wr_en, wr_data         data register write (ignored while tip)
//   miso / mosi            serial in / out
//   tip, last              to clock generator enable / last_clk
//   done                   one-cycle pulse at transfer end
//   rx_data                data register contents
module spi_shifter #(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 5
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [LEN_W-1:0]  len,
    input  logic              lsb,
    input  logic              tx_negedge,
    input  logic              rx_negedge,
    input  logic              go,
    input  logic              pos_edge,
    input  logic              neg_edge,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              miso,
    output logic              mosi,
    output logic              tip,
    output logic              last,
    output logic              done,
    output logic [DATA_W-1:0] rx_data
);

    localparam int CW = LEN_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        TAIL
    } state_t;

    state_t            r_state;
    logic [DATA_W-1:0] r_data;
    logic              r_mosi;
    logic              r_tip;
    logic              r_last;
    logic              r_done;
    logic [CW-1:0]     r_tx_cnt;
    logic [CW-1:0]     r_rx_cnt;
    logic [CW-1:0]     r_n;
    logic              r_lsb;
    logic              r_txneg;
    logic              r_rxneg;

    state_t            w_state_n;
    logic [DATA_W-1:0] w_data_n;
    logic              w_mosi_n;
    logic              w_tip_n;
    logic              w_last_n;
    logic              w_done_n;
    logic [CW-1:0]     w_tx_cnt_n;
    logic [CW-1:0]     w_rx_cnt_n;
    logic [CW-1:0]     w_n_n;
    logic              w_lsb_n;
    logic              w_txneg_n;
    logic              w_rxneg_n;
    logic [CW-1:0]     w_n;
    logic              w_tx_edge;
    logic              w_rx_edge;

    // Register position of the k-th serial bit of an n-bit character.
    function automatic logic [LEN_W-1:0] f_idx(
        input logic [CW-1:0] n,
        input logic [CW-1:0] k,
        input logic          lsb_first
    );
        logic [CW-1:0] v;
        v = lsb_first ? k : (n - CW'(1) - k);
        return v[LEN_W-1:0];
    endfunction

    assign w_n       = (len == '0) ? CW'(DATA_W) : {1'b0, len};
    assign w_tx_edge = r_txneg ? neg_edge : pos_edge;
    assign w_rx_edge = r_rxneg ? neg_edge : pos_edge;

    always_comb begin
        w_state_n  = r_state;
        w_data_n   = r_data;
        w_mosi_n   = r_mosi;
        w_tip_n    = r_tip;
        w_done_n   = 1'b0;
        w_tx_cnt_n = r_tx_cnt;
        w_rx_cnt_n = r_rx_cnt;
        w_n_n      = r_n;
        w_lsb_n    = r_lsb;
        w_txneg_n  = r_txneg;
        w_rxneg_n  = r_rxneg;
        unique case (r_state)
            IDLE: begin
                if (wr_en) begin
                    w_data_n = wr_data;
                end else if (go) begin
                    w_state_n  = SHIFT;
                    w_mosi_n   = r_data[f_idx(w_n, '0, lsb)];
                    w_tx_cnt_n = w_n - CW'(1);
                    w_rx_cnt_n = w_n;
                    w_tip_n    = 1'b1;
                    w_n_n      = w_n;
                    w_lsb_n    = lsb;
                    w_txneg_n  = tx_negedge;
                    w_rxneg_n  = rx_negedge;
                end
            end
            SHIFT: begin
                // TX reads r_data; RX only overwrites an index already sent.
                if (w_tx_edge && r_tx_cnt != '0) begin
                    w_mosi_n   = r_data[f_idx(r_n, r_n - r_tx_cnt, r_lsb)];
                    w_tx_cnt_n = r_tx_cnt - CW'(1);
                end
                if (w_rx_edge && r_rx_cnt != '0) begin
                    w_data_n[f_idx(r_n, r_n - r_rx_cnt, r_lsb)] = miso;
                    w_rx_cnt_n = r_rx_cnt - CW'(1);
                    if (r_rx_cnt == CW'(1)) begin
                        w_state_n = TAIL;
                    end
                end
            end
            TAIL: begin
                // One more edge lets SCK settle back to its idle level.
                if (pos_edge || neg_edge) begin
                    w_state_n = IDLE;
                    w_tip_n   = 1'b0;
                    w_done_n  = 1'b1;
                end
            end
            default: begin
                w_state_n = IDLE;
            end
        endcase
        w_last_n = w_tip_n && (w_rx_cnt_n <= CW'(1));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= IDLE;
            r_data   <= '0;
            r_mosi   <= 1'b0;
            r_tip    <= 1'b0;
            r_last   <= 1'b0;
            r_done   <= 1'b0;
            r_tx_cnt <= '0;
            r_rx_cnt <= '0;
            r_n      <= '0;
            r_lsb    <= 1'b0;
            r_txneg  <= 1'b0;
            r_rxneg  <= 1'b0;
        end else begin
            r_state  <= w_state_n;
            r_data   <= w_data_n;
            r_mosi   <= w_mosi_n;
            r_tip    <= w_tip_n;
            r_last   <= w_last_n;
            r_done   <= w_done_n;
            r_tx_cnt <= w_tx_cnt_n;
            r_rx_cnt <= w_rx_cnt_n;
            r_n      <= w_n_n;
            r_lsb    <= w_lsb_n;
            r_txneg  <= w_txneg_n;
            r_rxneg  <= w_rxneg_n;
        end
    end

    assign mosi    = r_mosi;
    assign tip     = r_tip;
    assign last    = r_last;
    assign done    = r_done;
    assign rx_data = r_data;

endmodule

// File: doc/spi_shifter.md
Name: spi_shifter

Overview:
- Data shift stage of the SPI host. It sits directly downstream of the SPI clock generator and consumes that block's pos_edge and neg_edge pulses.
- Drives MOSI and samples MISO on the selected edges. Holds one character of up to DATA_W bits in a shared TX/RX register.
- Returns tip, to be used as the clock generator's enable, and last, to be used as its last_clk.

Parameters:
DATA_W, 32, maximum character length in bits; also the width of the data register
LEN_W, 5, width of the len field; must satisfy 2**LEN_W == DATA_W

Ports:
clk_i  input  1  system clock
rst_ni  input  1  asynchronous active-low reset
len  input  LEN_W  character length; 0 encodes DATA_W bits, any other value encodes that many bits
lsb  input  1  1 = LSB first, 0 = MSB first
tx_negedge  input  1  1 = drive MOSI on neg_edge, 0 = drive on pos_edge
rx_negedge  input  1  1 = sample MISO on neg_edge, 0 = sample on pos_edge
go  input  1  start-transfer pulse
pos_edge  input  1  clock-generator rising-edge pulse
neg_edge  input  1  clock-generator falling-edge pulse
wr_en  input  1  data register write strobe
wr_data  input  DATA_W  data register write value
miso  input  1  serial input
mosi  output  1  serial output
tip  output  1  transfer in progress; to the clock generator's enable
last  output  1  final clock phase; to the clock generator's last_clk
done  output  1  one-cycle pulse at transfer end
rx_data  output  DATA_W  data register contents (RX result after done)

Behaviour:
- Reset values: state=IDLE, data=0, mosi=0, tip=0, last=0, done=0, tx_cnt=0, rx_cnt=0.
- N = (len==0) ? DATA_W : len. N is latched at start; changes to len, lsb or the edge-select inputs during a transfer are ignored.
- tx_edge = tx_negedge ? neg_edge : pos_edge. rx_edge = rx_negedge ? neg_edge : pos_edge.
- Bit index of the k-th bit (k = 0..N-1): lsb ? k : N-1-k.
- States are IDLE, SHIFT and TAIL.
- IDLE:
  - wr_en writes data <= wr_data.
  - go && !wr_en → SHIFT. On the same edge: mosi <= data[idx(0)], tx_cnt <= N-1, rx_cnt <= N, tip <= 1.
  - go && wr_en in the same cycle: the write is accepted and go is ignored.
- SHIFT:
  - tx_edge && tx_cnt!=0 → mosi <= data[idx(N-tx_cnt)], tx_cnt <= tx_cnt-1.
  - tx_edge with tx_cnt==0 is ignored.
  - rx_edge → data[idx(N-rx_cnt)] <= miso, rx_cnt <= rx_cnt-1.
  - When rx_cnt goes 1→0, move to TAIL.
  - If tx and rx edges coincide, both act in the same cycle. TX reads the old register value, which is safe because RX always writes an already-transmitted index.
- TAIL:
  - The first pos_edge or neg_edge → IDLE, tip <= 0, done <= 1 for exactly one cycle.
  - This lets the serial clock return to its idle level.
- last is registered: last = tip && (rx_cnt <= 1). It is asserted from the cycle after the (N-1)th rx_edge until tip falls.
- wr_en is ignored while tip=1. go is ignored while tip=1.
- mosi holds its last driven value after the transfer and in IDLE.
- rx_data is continuously equal to the data register.
- Counters are LEN_W+1 bits wide so that N=DATA_W fits. No wrap-around occurs: decrements are gated by the zero checks.
- Reset asserted mid-transfer: immediate return to the reset values; the partial character is discarded.

Test Plan:
- Mode 0 (tx_negedge=1, rx_negedge=0), len=8, lsb=0, data=0x000000A5, miso looped to mosi:
  - mosi sequence 1,0,1,0,0,1,0,1.
  - done pulses once after the 8th pos_edge plus one further edge.
  - rx_data=0x000000A5.
  - last rises after the 7th pos_edge.
- len=0, lsb=1, data=0x80000001, miso tied 0:
  - 32 bits shifted, mosi first bit 1, last bit 1.
  - rx_data=0x00000000.
  - tip high for 32 rx_edges plus tail.
- tx_negedge=rx_negedge=0 (same edge), len=4, lsb=1, data=0xC, miso driven 1,1,0,1:
  - mosi sequence 0,0,1,1.
  - rx_data[3:0]=0xB.
- Mid-transfer disturbances:
  - wr_en=1 with wr_data=0xFFFFFFFF during SHIFT → data register unchanged apart from received bits.
  - go re-pulsed during SHIFT → no restart; tx_cnt and rx_cnt unaffected.
- Reset and start collision:
  - rst_ni pulsed low after 3 of 8 bits → tip=0, done=0, data=0 immediately; a new go afterwards completes normally.
  - go and wr_en in the same IDLE cycle → data written, tip stays 0.
